// File: rtl/mbist_pkg.sv
// Shared definitions for the MBIST fail logger: FSM state codes, default
// widths and the log-entry width helper.
// Build option: define MBIST_LOG_DATA_EN to store expected/actual data per entry.
package mbist_pkg;

    // Default configuration
    localparam int unsigned DefAw    = 8;
    localparam int unsigned DefDw    = 4;
    localparam int unsigned DefDepth = 8;
    localparam int unsigned DefCw    = 12;

    // FSM state codes
    typedef logic [1:0] state_t;
    localparam state_t StIdle  = 2'd0;
    localparam state_t StArmed = 2'd1;
    localparam state_t StDone  = 2'd2;

    // Width of one stored fail-log entry.
    function automatic int unsigned log_entry_w(input int unsigned aw, input int unsigned dw);
`ifdef MBIST_LOG_DATA_EN
        return aw + 2 * dw;
`else
        // Address-only build; dw has no bearing on storage.
        return aw + 0 * dw;
`endif
    endfunction

endpackage

// File: rtl/mbist_log_fifo.sv
// Fail-log FIFO: power-of-two depth, synchronous flush that wins over push/pop,
// registered storage so a pushed word appears at the head on the next cycle.
// A push while full is only taken when a pop happens in the same cycle.
module mbist_log_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Extra pointer MSB distinguishes full from empty.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q[PW-1:0]];

    // Pointer next-state; flush empties the FIFO and overrides any pop/push.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + (PW + 1)'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + (PW + 1)'(1);
        end
    end

    // Pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i && !rst) mem_q[wr_ptr_q[PW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/mbist_fail_logger.sv
// MBIST fail logger: tracks a BIST run (IDLE/ARMED/DONE) from test_active edges,
// counts miscompares with saturation, remembers the first failing address and
// queues fail records in a FIFO that can be drained at any time.
// Build option: define MBIST_LOG_DATA_EN to log expected/actual data; otherwise
// only addresses are stored and log_exp/log_act read as zero.
module mbist_fail_logger
    import mbist_pkg::*;
#(
    parameter int unsigned AW    = DefAw,
    parameter int unsigned DW    = DefDw,
    parameter int unsigned DEPTH = DefDepth,
    parameter int unsigned CW    = DefCw
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          test_active,
    input  logic          fail_in,
    input  logic [AW-1:0] fail_addr,
    input  logic [DW-1:0] fail_exp,
    input  logic [DW-1:0] fail_act,
    output logic          log_valid,
    input  logic          log_ready,
    output logic [AW-1:0] log_addr,
    output logic [DW-1:0] log_exp,
    output logic [DW-1:0] log_act,
    output logic [CW-1:0] fail_count,
    output logic [AW-1:0] first_addr,
    output logic          first_valid,
    output logic          overflow,
    output logic          done,
    output logic          pass
);

    localparam int unsigned LW     = log_entry_w(AW, DW);
    localparam logic [CW-1:0] CntMax = {CW{1'b1}};

    state_t        state_q, state_d;
    logic          ta_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] first_addr_q, first_addr_d;
    logic          first_valid_q, first_valid_d;
    logic          ovf_q, ovf_d;

    logic          ta_rise, ta_fall, arm_entry, accept, pop;
    logic          fifo_full, fifo_empty;
    logic [LW-1:0] wr_entry, rd_entry;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_exp, head_act;

    assign ta_rise   = test_active && !ta_q;
    assign ta_fall   = !test_active && ta_q;
    assign arm_entry = ta_rise && (state_q != StArmed);
    // The falling-edge cycle is still ARMED, so a fail there is accepted.
    assign accept    = fail_in && (state_q == StArmed);
    assign pop       = log_valid && log_ready;

`ifdef MBIST_LOG_DATA_EN
    assign wr_entry = {fail_addr, fail_exp, fail_act};
    assign {head_addr, head_exp, head_act} = rd_entry;
`else
    logic unused_data;
    assign unused_data = ^{fail_exp, fail_act};
    assign wr_entry    = fail_addr;
    assign head_addr   = rd_entry;
    assign head_exp    = '0;
    assign head_act    = '0;
`endif

    mbist_log_fifo #(
        .WIDTH (LW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (arm_entry),
        .push_i  (accept),
        .wdata_i (wr_entry),
        .pop_i   (pop),
        .rdata_o (rd_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Run state follows test_active edges.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (ta_rise) state_d = StArmed;
            StArmed: if (ta_fall) state_d = StDone;
            StDone:  if (ta_rise) state_d = StArmed;
            default: state_d = StIdle;
        endcase
    end

    // Run statistics: cleared on each arm, updated by accepted fails.
    always_comb begin
        cnt_d         = cnt_q;
        first_addr_d  = first_addr_q;
        first_valid_d = first_valid_q;
        ovf_d         = ovf_q;
        if (arm_entry) begin
            cnt_d         = '0;
            first_addr_d  = '0;
            first_valid_d = 1'b0;
            ovf_d         = 1'b0;
        end else if (accept) begin
            if (cnt_q != CntMax) cnt_d = cnt_q + CW'(1);
            if (!first_valid_q) begin
                first_addr_d  = fail_addr;
                first_valid_d = 1'b1;
            end
            // Entry is dropped only when full and nothing leaves this cycle.
            if (fifo_full && !pop) ovf_d = 1'b1;
        end
    end

    // State registers; test_active is sampled during reset so a level held
    // high across reset release is not seen as a rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            ta_q          <= test_active;
            cnt_q         <= '0;
            first_addr_q  <= '0;
            first_valid_q <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            ta_q          <= test_active;
            cnt_q         <= cnt_d;
            first_addr_q  <= first_addr_d;
            first_valid_q <= first_valid_d;
            ovf_q         <= ovf_d;
        end
    end

    // Outputs; head fields read zero whenever the FIFO is empty.
    always_comb begin
        log_valid   = !fifo_empty;
        log_addr    = log_valid ? head_addr : '0;
        log_exp     = log_valid ? head_exp  : '0;
        log_act     = log_valid ? head_act  : '0;
        fail_count  = cnt_q;
        first_addr  = first_addr_q;
        first_valid = first_valid_q;
        overflow    = ovf_q;
        done        = (state_q == StDone);
        pass        = done && (cnt_q == '0);
    end

endmodule

// File: tb/tb_mbist_fail_logger.sv
// Bench for mbist_fail_logger: a run-level reference model predicts the
// statistics and the log contents; a negedge monitor compares the DUT each
// cycle and pops expected log records as the DUT hands them out.
module tb_mbist_fail_logger;

    localparam int DEPTH = 8;

    typedef struct packed {
        logic [7:0] a;
        logic [3:0] e;
        logic [3:0] x;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       test_active = 1'b0;
    logic       fail_in = 1'b0;
    logic [7:0] fail_addr = '0;
    logic [3:0] fail_exp = '0;
    logic [3:0] fail_act = '0;
    logic       log_ready = 1'b0;

    logic        log_valid, first_valid, overflow, done, pass;
    logic [7:0]  log_addr, first_addr;
    logic [3:0]  log_exp, log_act;
    logic [11:0] fail_count;

    logic        s_log_valid, s_first_valid, s_overflow, s_done, s_pass;
    logic [7:0]  s_log_addr, s_first_addr;
    logic [3:0]  s_log_exp, s_log_act;
    logic [3:0]  s_fail_count;

    always #5 clk = ~clk;

    mbist_fail_logger u_dut (
        .clk(clk), .rst(rst), .test_active(test_active), .fail_in(fail_in),
        .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_act(fail_act),
        .log_valid(log_valid), .log_ready(log_ready), .log_addr(log_addr),
        .log_exp(log_exp), .log_act(log_act), .fail_count(fail_count),
        .first_addr(first_addr), .first_valid(first_valid), .overflow(overflow),
        .done(done), .pass(pass)
    );

    // Narrow-counter instance for saturation.
    mbist_fail_logger #(.CW(4)) u_sat (
        .clk(clk), .rst(rst), .test_active(test_active), .fail_in(fail_in),
        .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_act(fail_act),
        .log_valid(s_log_valid), .log_ready(log_ready), .log_addr(s_log_addr),
        .log_exp(s_log_exp), .log_act(s_log_act), .fail_count(s_fail_count),
        .first_addr(s_first_addr), .first_valid(s_first_valid), .overflow(s_overflow),
        .done(s_done), .pass(s_pass)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state after the edge currently being driven
    bit   m_arm = 0, m_done = 0, m_fv = 0, m_ovf = 0, m_prev = 0, m_flush = 1;
    int   m_n = 0, m_occ = 0;
    logic [7:0] m_first = '0;
    ent_t sb[$];

    // Model state visible at the DUT outputs now
    bit   v_done = 0, v_fv = 0, v_ovf = 0;
    int   v_n = 0, v_occ = 0;
    logic [7:0] v_first = '0;
    bit   chk_en = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic int sat(input int n, input int maxv);
        return (n > maxv) ? maxv : n;
    endfunction

    always @(posedge clk) begin
        v_done  <= m_done;
        v_fv    <= m_fv;
        v_ovf   <= m_ovf;
        v_n     <= m_n;
        v_occ   <= m_occ;
        v_first <= m_first;
    end

    // Monitor: statistics every cycle, log head against scoreboard front.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("fail_count", 32'(fail_count), 32'(sat(v_n, 4095)));
            chk("fail_count_cw4", 32'(s_fail_count), 32'(sat(v_n, 15)));
            chk("first_valid", 32'(first_valid), 32'(v_fv));
            chk("first_addr", 32'(first_addr), 32'(v_first));
            chk("overflow", 32'(overflow), 32'(v_ovf));
            chk("done", 32'(done), 32'(v_done));
            chk("pass", 32'(pass), 32'(v_done && v_n == 0));
            chk("log_valid", 32'(log_valid), 32'(v_occ > 0));
            if (!m_flush && log_valid) begin
                if (sb.size() == 0) begin
                    chk("log_head_present", 32'(log_addr), 32'hFFFF_FFFF);
                end else begin
                    chk("log_addr", 32'(log_addr), 32'(sb[0].a));
`ifdef MBIST_LOG_DATA_EN
                    chk("log_exp", 32'(log_exp), 32'(sb[0].e));
                    chk("log_act", 32'(log_act), 32'(sb[0].x));
`else
                    chk("log_exp", 32'(log_exp), 32'(0));
                    chk("log_act", 32'(log_act), 32'(0));
`endif
                    if (log_ready) void'(sb.pop_front());
                end
            end
        end
    end

    // Drive one cycle and advance the reference model to the following edge.
    task automatic step(input logic ta, input logic f, input logic [7:0] a,
                        input logic [3:0] e, input logic [3:0] x,
                        input logic rdy, input logic rs);
        bit rise, pop;
        ent_t ent;
        @(posedge clk);
        #1;
        rst = rs; test_active = ta; fail_in = f;
        fail_addr = a; fail_exp = e; fail_act = x; log_ready = rdy;
        m_flush = 0;
        if (rs) begin
            m_arm = 0; m_done = 0; m_n = 0; m_fv = 0; m_first = '0; m_ovf = 0;
            m_occ = 0; sb.delete(); m_flush = 1; m_prev = ta;
        end else begin
            rise   = ta && !m_prev;
            m_prev = ta;
            pop    = (m_occ > 0) && rdy;
            if (rise && !m_arm) begin
                m_arm = 1; m_done = 0; m_n = 0; m_fv = 0; m_first = '0; m_ovf = 0;
                m_occ = 0; sb.delete(); m_flush = 1;
            end else begin
                if (m_arm && f) begin
                    m_n++;
                    if (!m_fv) begin m_fv = 1; m_first = a; end
                    if (m_occ == DEPTH && !pop) m_ovf = 1;
                    else begin
                        ent.a = a; ent.e = e; ent.x = x;
                        sb.push_back(ent);
                        m_occ++;
                    end
                end
                if (pop) m_occ--;
                if (m_arm && !ta) begin m_arm = 0; m_done = 1; end
            end
        end
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, 4'h0, 4'h0, rdy, 0);
    endtask

    initial begin
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        chk_en = 1;
        idle(2, 0);

        // Clean run
        for (int i = 0; i < 100; i++) step(1, 0, 0, 0, 0, 0, 0);
        idle(3, 0);

        // Single fail, held undrained, then drained
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 8'h2A, 4'h5, 4'h4, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, 0);
        idle(3, 0);
        idle(3, 1);

        // Overflow: ten fails into eight entries
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 1, 8'(i), 4'(i), 4'(~i), 0, 0);
        idle(2, 0);
        idle(DEPTH + 2, 1);

        // Full with simultaneous pop and push
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(1, 1, 8'(8'h10 + i), 4'h3, 4'h2, 0, 0);
        step(1, 1, 8'h80, 4'hA, 4'hB, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        idle(DEPTH + 2, 1);

        // Rerun clears; saturation with 20 fails; fail on falling-edge cycle
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(1, 1, 8'(8'h40 + i), 4'h1, 4'h0, 1, 0);
        step(0, 1, 8'h77, 4'h7, 4'h6, 1, 0);
        step(0, 1, 8'h78, 4'h7, 4'h6, 1, 0);
        idle(DEPTH + 2, 1);

        // Reset mid-run with test_active held high: no edge at release
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 8'h33, 4'h1, 4'h2, 0, 0);
        step(1, 1, 8'h34, 4'h1, 4'h2, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 1, 8'h99, 4'h9, 4'h9, 0, 0);
        idle(2, 0);

        // Randomised runs
        for (int r = 0; r < 8; r++) begin
            int len;
            len = $urandom_range(60, 15);
            for (int i = 0; i < len; i++)
                step(1, ($urandom_range(99, 0) < 35), 8'($urandom), 4'($urandom),
                     4'($urandom), ($urandom_range(99, 0) < 40), 0);
            for (int i = 0; i < 6; i++)
                step(0, ($urandom_range(1, 0) == 1), 8'($urandom), 4'($urandom),
                     4'($urandom), ($urandom_range(1, 0) == 1), 0);
        end

        idle(DEPTH + 4, 1);
        chk("scoreboard_drained", 32'(sb.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
